// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline controller: FSM encoding, widths and
// reset/stall polarity constants.
package pipe_ctrl_pkg;

    localparam int   NSTAGE_DEF = 6;
    localparam int   PC_W       = 32;

    localparam logic RST_ENABLE = 1'b0;
    localparam logic STOP       = 1'b1;
    localparam logic NO_STOP    = 1'b0;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    // A zero-length flush would never assert flush, so clamp it to one cycle.
    function automatic int flushLoad(input int n);
        return (n < 1) ? 1 : n;
    endfunction

endpackage

// File: rtl/pipe_ctrl_prio.sv
// Highest-set-bit to stall-mask encoder: stage k is held when any stage at or
// beyond k requests a stall.
module pipe_ctrl_prio
    import pipe_ctrl_pkg::*;
#(
    parameter int NSTAGE = NSTAGE_DEF
) (
    input  logic [NSTAGE-1:0] i_req,
    output logic [NSTAGE-1:0] o_mask
);

    genvar k;
    generate
        for (k = 0; k < NSTAGE; k++) begin : g_mask
            assign o_mask[k] = |i_req[NSTAGE-1:k];
        end
    endgenerate

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: combinational stall mask, exception-driven
// flush sequencing, stall statistics and a sticky stall watchdog.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int NSTAGE       = NSTAGE_DEF,
    parameter int FLUSH_CYCLES = 1,
    parameter int TIMEOUT      = 255,
    parameter int CNT_W        = 32
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [NSTAGE-1:0] i_stallreq,
    input  logic              i_excp_valid,
    input  logic [PC_W-1:0]   i_excp_pc,
    output logic [NSTAGE-1:0] o_stall,
    output logic              o_flush,
    output logic [PC_W-1:0]   o_new_pc,
    output logic [CNT_W-1:0]  o_stall_cnt,
    output logic              o_stall_timeout
);

    localparam int FLUSH_EFF = flushLoad(FLUSH_CYCLES);
    localparam int FC_W      = $clog2(FLUSH_EFF + 1);
    localparam int TO_W      = $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT);
    localparam logic [FC_W-1:0] FC_ONE = FC_W'(1);

    state_t            r_state;
    state_t            w_next_state;
    logic              r_flush;
    logic [PC_W-1:0]   r_new_pc;
    logic [FC_W-1:0]   r_flush_cnt;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic [TO_W-1:0]   r_consec;
    logic              r_timeout;
    logic [NSTAGE-1:0] w_mask;
    logic [NSTAGE-1:0] w_stall;
    logic              w_any_stall;
    logic              w_take_excp;

    pipe_ctrl_prio #(
        .NSTAGE (NSTAGE)
    ) u_prio (
        .i_req  (i_stallreq),
        .o_mask (w_mask)
    );

    always_comb begin
        w_next_state = r_state;
        w_stall      = '0;
        w_take_excp  = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (i_excp_valid) begin
                    w_next_state = ST_FLUSH;
                    w_take_excp  = 1'b1;
                end else begin
                    w_stall = w_mask;
                end
            end
            ST_FLUSH: begin
                if (r_flush_cnt <= FC_ONE) begin
                    w_next_state = ST_RUN;
                end
            end
            default: w_next_state = ST_RUN;
        endcase
    end

    assign w_any_stall = |w_stall;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (i_rst_n == RST_ENABLE) begin
            r_state     <= ST_RUN;
            r_flush     <= 1'b0;
            r_new_pc    <= '0;
            r_flush_cnt <= '0;
            r_stall_cnt <= '0;
            r_consec    <= '0;
            r_timeout   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_flush <= (w_next_state == ST_FLUSH);

            if (w_take_excp) begin
                r_new_pc    <= i_excp_pc;
                r_flush_cnt <= FC_W'(FLUSH_EFF);
            end else if (r_state == ST_FLUSH && r_flush_cnt > FC_ONE) begin
                r_flush_cnt <= r_flush_cnt - FC_ONE;
            end

            if (w_any_stall && r_stall_cnt != '1) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end

            // Entering flush restarts the watchdog; otherwise count consecutive stalls.
            if (w_take_excp) begin
                r_consec  <= '0;
                r_timeout <= 1'b0;
            end else if (w_any_stall) begin
                if (r_consec < TO_MAX) begin
                    r_consec <= r_consec + TO_W'(1);
                end
                if (r_consec >= TO_MAX - TO_W'(1)) begin
                    r_timeout <= 1'b1;
                end
            end else begin
                r_consec <= '0;
            end
        end
    end

    assign o_stall         = (i_rst_n == RST_ENABLE) ? '0 : w_stall;
    assign o_flush         = r_flush;
    assign o_new_pc        = r_new_pc;
    assign o_stall_cnt     = r_stall_cnt;
    assign o_stall_timeout = r_timeout;

endmodule
